// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-coded position link receive path:
// step-direction codes and the decoder's tracking state encoding.
package gray_pkg;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [1:0] DIR_BAD  = 2'b11;

    typedef enum logic {
        ST_NOPREV = 1'b0,
        ST_TRACK  = 1'b1
    } state_t;

endpackage

// File: rtl/gray_stream_decoder_if.sv
// Valid/ready stream bundle for the Gray decoder: Gray words in, binary
// value plus step classification and error count out.
interface gray_stream_decoder_if #(
    parameter int WIDTH = 3,
    parameter int ERRW  = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bin;
    logic [1:0]       out_dir;
    logic             out_step_err;
    logic [ERRW-1:0]  err_count;

    // master: Gray source plus binary consumer; slave: the decoder.
    modport master (
        output in_valid, in_gray, out_ready,
        input  in_ready, out_valid, out_bin, out_dir, out_step_err, err_count
    );

    modport slave (
        input  in_valid, in_gray, out_ready,
        output in_ready, out_valid, out_bin, out_dir, out_step_err, err_count
    );
endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of
// all Gray bits at or above its position.
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Prefix-XOR form avoids a bit-to-bit chain on the same vector.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign bin[gi] = ^gray[WIDTH-1:gi];
    end

endmodule

// File: rtl/gray_stream_decoder.sv
// Registered Gray-to-binary stream decoder that classifies each accepted
// step against the previous word and counts illegal steps (saturating).
module gray_stream_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int ERRW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gray_stream_decoder_if.slave bus
);

    localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_NEG = '1;
    localparam logic [ERRW-1:0]  ERR_MAX  = '1;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] prev_bin_reg, prev_bin_next;
    logic [WIDTH-1:0] out_bin_reg, out_bin_next;
    logic [1:0]       out_dir_reg, out_dir_next;
    logic             out_step_err_reg, out_step_err_next;
    logic             out_valid_reg, out_valid_next;
    logic [ERRW-1:0]  err_count_reg, err_count_next;

    logic [WIDTH-1:0] dec_bin;
    logic [WIDTH-1:0] step;
    logic             in_ready;
    logic             accept;
    logic             illegal;

    gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
        .gray (bus.in_gray),
        .bin  (dec_bin)
    );

    // A held word blocks input unless it drains on this same edge.
    assign in_ready = !out_valid_reg || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign step     = dec_bin - prev_bin_reg;

    always_comb begin
        state_next        = state_reg;
        prev_bin_next     = prev_bin_reg;
        out_bin_next      = out_bin_reg;
        out_dir_next      = out_dir_reg;
        out_step_err_next = out_step_err_reg;
        out_valid_next    = out_valid_reg;
        err_count_next    = err_count_reg;
        illegal           = 1'b0;

        if (accept) begin
            state_next     = ST_TRACK;
            prev_bin_next  = dec_bin;
            out_bin_next   = dec_bin;
            out_valid_next = 1'b1;
            case (state_reg)
                ST_NOPREV: begin
                    out_dir_next      = DIR_BAD;
                    out_step_err_next = 1'b0;
                end
                ST_TRACK: begin
                    out_step_err_next = 1'b0;
                    if (step == '0) begin
                        out_dir_next = DIR_HOLD;
                    end else if (step == STEP_ONE) begin
                        out_dir_next = DIR_UP;
                    end else if (step == STEP_NEG) begin
                        out_dir_next = DIR_DOWN;
                    end else begin
                        out_dir_next      = DIR_BAD;
                        out_step_err_next = 1'b1;
                        illegal           = 1'b1;
                    end
                end
                default: begin
                    out_dir_next      = DIR_BAD;
                    out_step_err_next = 1'b0;
                end
            endcase
        end else if (bus.out_ready) begin
            out_valid_next = 1'b0;
        end

        if (illegal && (err_count_reg != ERR_MAX)) begin
            err_count_next = err_count_reg + ERRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_NOPREV;
            prev_bin_reg     <= '0;
            out_bin_reg      <= '0;
            out_dir_reg      <= DIR_HOLD;
            out_step_err_reg <= 1'b0;
            out_valid_reg    <= 1'b0;
            err_count_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            prev_bin_reg     <= prev_bin_next;
            out_bin_reg      <= out_bin_next;
            out_dir_reg      <= out_dir_next;
            out_step_err_reg <= out_step_err_next;
            out_valid_reg    <= out_valid_next;
            err_count_reg    <= err_count_next;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_bin      = out_bin_reg;
    assign bus.out_dir      = out_dir_reg;
    assign bus.out_step_err = out_step_err_reg;
    assign bus.err_count    = err_count_reg;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder: two instances (ERRW=8 and ERRW=2) share one
// stimulus stream and are checked each cycle against a behavioural model.
module tb_gray_stream_decoder;

    localparam int W   = 3;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_gray = '0;
    logic         out_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    gray_stream_decoder_if #(.WIDTH(W), .ERRW(8)) bus1 ();
    gray_stream_decoder_if #(.WIDTH(W), .ERRW(2)) bus2 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_gray   = in_gray;
    assign bus1.out_ready = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_gray   = in_gray;
    assign bus2.out_ready = out_ready;

    gray_stream_decoder #(.WIDTH(W), .ERRW(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    gray_stream_decoder #(.WIDTH(W), .ERRW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < W; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [1:0] classify(input logic has_prev, input logic [W-1:0] b,
                                            input logic [W-1:0] p);
        int d;
        if (!has_prev) return 2'b11;
        d = (int'(b) - int'(p) + MOD) % MOD;
        if (d == 0) return 2'b00;
        if (d == 1) return 2'b01;
        if (d == MOD - 1) return 2'b10;
        return 2'b11;
    endfunction

    logic         m_valid, m_err, m_has_prev;
    logic [W-1:0] m_bin, m_prev;
    logic [1:0]   m_dir;
    int           m_cnt1, m_cnt2;

    logic [W-1:0] mdl_new_bin;
    logic [1:0]   mdl_dir;
    logic         mdl_acc, mdl_bad;
    assign mdl_new_bin = g2b(in_gray);
    assign mdl_dir     = classify(m_has_prev, mdl_new_bin, m_prev);
    assign mdl_acc     = in_valid && (!m_valid || out_ready);
    assign mdl_bad     = m_has_prev && (mdl_dir == 2'b11);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_bin <= '0; m_dir <= 2'b00; m_err <= 1'b0;
            m_has_prev <= 1'b0; m_prev <= '0; m_cnt1 <= 0; m_cnt2 <= 0;
        end else if (mdl_acc) begin
            m_valid    <= 1'b1;
            m_bin      <= mdl_new_bin;
            m_dir      <= mdl_dir;
            m_err      <= mdl_bad;
            m_has_prev <= 1'b1;
            m_prev     <= mdl_new_bin;
            if (mdl_bad) begin
                m_cnt1 <= (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
                m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
            $display("[TB] xfer t=%0t gray=%b bin=%0d dir=%b", $time, in_gray, mdl_new_bin, mdl_dir);
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison, sampled just after the falling edge.
    always @(negedge clk) begin
        #1;
        chk("in_ready",   32'(bus1.in_ready),     32'(!m_valid || out_ready));
        chk("out_valid",  32'(bus1.out_valid),    32'(m_valid));
        chk("out_bin",    32'(bus1.out_bin),      32'(m_bin));
        chk("out_dir",    32'(bus1.out_dir),      32'(m_dir));
        chk("step_err",   32'(bus1.out_step_err), 32'(m_err));
        chk("err_count",  32'(bus1.err_count),    32'(m_cnt1));
        chk("out_valid2", 32'(bus2.out_valid),    32'(m_valid));
        chk("out_bin2",   32'(bus2.out_bin),      32'(m_bin));
        chk("out_dir2",   32'(bus2.out_dir),      32'(m_dir));
        chk("err_count2", 32'(bus2.err_count),    32'(m_cnt2));
    end

    // Send one word with out_ready high and check hand-computed results.
    task automatic send_chk(input logic [W-1:0] g, input int eb, input int ed, input int ee,
                            input int c1, input int c2);
        @(negedge clk);
        in_valid = 1'b1; in_gray = g; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("lit_valid", 32'(bus1.out_valid),    32'd1);
        chk("lit_bin",   32'(bus1.out_bin),      32'(eb));
        chk("lit_dir",   32'(bus1.out_dir),      32'(ed));
        chk("lit_err",   32'(bus1.out_step_err), 32'(ee));
        chk("lit_cnt",   32'(bus1.err_count),    32'(c1));
        chk("lit_cnt2",  32'(bus2.err_count),    32'(c2));
    endtask

    initial begin
        logic [W-1:0] drv_bin;
        logic [W-1:0] seq [8];
        seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b011; seq[3] = 3'b010;
        seq[4] = 3'b110; seq[5] = 3'b111; seq[6] = 3'b101; seq[7] = 3'b100;

        #1;
        chk("rst_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_bin",   32'(bus1.out_bin),   32'd0);
        chk("rst_cnt",   32'(bus1.err_count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Counting sequence 0..7: first word has no predecessor.
        for (int i = 0; i < 8; i++)
            send_chk(seq[i], i, (i == 0) ? 3 : 1, 0, 0, 0);
        send_chk(3'b000, 0, 1, 0, 0, 0);   // 7 -> 0 wraps up
        send_chk(3'b100, 7, 2, 0, 0, 0);   // 0 -> 7 wraps down
        send_chk(3'b100, 7, 0, 0, 0, 0);   // hold
        send_chk(3'b000, 0, 1, 0, 0, 0);
        send_chk(3'b011, 2, 3, 1, 1, 1);   // skip of two: illegal
        send_chk(3'b010, 3, 1, 0, 1, 1);   // resynchronised to 2

        // Back-pressure: the held word must not move for 5 cycles.
        @(negedge clk);
        in_valid = 1'b1; in_gray = 3'b110; out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_ready", 32'(bus1.in_ready),  32'd0);
            chk("bp_valid", 32'(bus1.out_valid), 32'd1);
            chk("bp_bin",   32'(bus1.out_bin),   32'd3);
            chk("bp_dir",   32'(bus1.out_dir),   32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_bin", 32'(bus1.out_bin), 32'd4);
        chk("bp_release_dir", 32'(bus1.out_dir), 32'd1);

        // Asynchronous reset in the middle of a transfer.
        @(negedge clk);
        in_gray = 3'b111;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus1.out_valid), 32'd0);
        chk("mid_rst_bin",   32'(bus1.out_bin),   32'd0);
        chk("mid_rst_dir",   32'(bus1.out_dir),   32'd0);
        chk("mid_rst_cnt",   32'(bus1.err_count), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_chk(3'b010, 3, 3, 0, 0, 0);

        // Illegal steps: ERRW=2 instance saturates at 3.
        send_chk(3'b101, 6, 3, 1, 1, 1);
        send_chk(3'b001, 1, 3, 1, 2, 2);
        send_chk(3'b110, 4, 3, 1, 3, 3);
        send_chk(3'b100, 7, 3, 1, 4, 3);
        send_chk(3'b011, 2, 3, 1, 5, 3);

        // Randomised traffic, mostly legal steps, with one async reset pulse.
        drv_bin = 3'd2;
        for (int c = 0; c < 400; c++) begin
            int r;
            @(negedge clk);
            if (c == 200) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            r = int'($urandom_range(0, 7));
            if (r <= 2)      drv_bin = drv_bin + 3'd1;
            else if (r == 3) drv_bin = drv_bin - 3'd1;
            else if (r == 5) drv_bin = W'($urandom);
            in_gray   = b2g(drv_bin);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gray_stream_decoder.md
# gray_stream_decoder

Registered Gray-to-binary decoder for the receive side of our Gray-coded position links: it accepts WIDTH-bit Gray words, as produced by the 3-bit Gray encoder stage, over a valid/ready stream and returns the binary value. It also tracks the previous accepted word, classifies each step as up, down, hold or illegal, and keeps a saturating error count. It sits between a Gray-coded source (counter, encoder wheel, CDC pointer) and binary consumers.

## Interface
- WIDTH, 3, Gray/binary word width (≥2)
- ERRW, 8, width of the saturating error counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_gray is valid
- in_ready  out  1  block can accept in_gray this cycle
- in_gray  in  WIDTH  Gray-coded input word
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts output this cycle
- out_bin  out  WIDTH  decoded binary value
- out_dir  out  2  step class: 00 hold, 01 up, 10 down, 11 illegal/first
- out_step_err  out  1  high with an output whose step is illegal
- err_count  out  ERRW  saturating count of illegal steps since reset

## Operation
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i] for i = WIDTH-2 down to 0.
- Accept = in_valid && in_ready; in_ready = !out_valid || out_ready. Full throughput: a new word can be accepted in the same cycle the held word drains.
- FSM, 2 states:
  - NOPREV (reset state): no previous word. On accept, move to TRACK. out_dir = 11, out_step_err = 0.
  - TRACK: on accept, compute d = new_bin − prev_bin mod 2^WIDTH. d = 0 → dir 00; d = 1 → 01; d = 2^WIDTH−1 → 10; any other d → dir 11, out_step_err = 1, err_count increments.
- Wrap-around is legal: 7→0 is up and 0→7 is down for WIDTH=3.
- prev_bin updates on every accept, including illegal steps. Tracking resynchronises to the new word.
- err_count saturates at 2^ERRW−1 and never wraps.
- out_bin, out_dir and out_step_err are held stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle. A word accepted at edge N appears with out_valid at edge N (registered) and is visible during cycle N+1.
- out_valid clears on the edge where out_ready is high and no new accept occurs.
- Reset, asynchronous and effective at any time including mid-transfer:
  - out_valid = 0, out_bin = 0, out_dir = 00, out_step_err = 0, err_count = 0.
  - prev_bin = 0 and FSM = NOPREV.
  - An in-flight output is discarded.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_gray to any output.

## Structure
- Shared package gray_pkg holds:
  - direction constants DIR_HOLD = 2'b00, DIR_UP = 2'b01, DIR_DOWN = 2'b10, DIR_BAD = 2'b11;
  - FSM state encoding.
- Sub-module gray_to_bin: combinational, parameter WIDTH, instantiated once. It is reusable elsewhere in the codebase.
- Top level holds the FSM, output register, prev_bin register, step classifier and counter.

## Test plan
- WIDTH=3, out_ready=1, feed Gray 000,001,011,010,110,111,101,100 → out_bin 0..7. First dir is 11 with no error; the rest are 01; err_count = 0.
- Then feed 000 → out_bin 0, dir 01 (wrap). Then feed 100 → out_bin 7, dir 10. Then feed 100 again → dir 00.
- From 000, feed 011 (bin 2) → dir 11, out_step_err = 1, err_count = 1. Next feed 010 (bin 3) → dir 01, no error.
- Hold out_ready = 0 with out_valid = 1 → in_ready = 0 and outputs unchanged for 5 cycles. Raise out_ready while in_valid = 1 → new word accepted on the same edge.
- Assert rst_n = 0 mid-stream with out_valid = 1 → all outputs zero immediately. After release, first word gives dir 11 and no error.
- ERRW=2: force 4 illegal steps → err_count reaches 3 and stays at 3.
